// File: rtl/stream_block_fetch.sv
// stream_block_fetch: packs a byte stream into BLOCK_BYTES-wide blocks.
// One packing register feeds one output register, so the next block is packed
// while the current one is held under backpressure. A short final block keeps
// its unfilled upper bytes at zero.
// Optional feature macro: FETCH_NOOP_EN. When defined, the DONE state streams
// all-zero NoOp blocks (out_count=0) whenever the output register is free.
module stream_block_fetch #(
  parameter int BLOCK_BYTES = 512,
  parameter int CNT_W       = $clog2(BLOCK_BYTES + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [8*BLOCK_BYTES-1:0] out_data,
  output logic [CNT_W-1:0]         out_count,
  output logic                     out_last,
  output logic                     done
);

  localparam int              DW       = 8 * BLOCK_BYTES;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BLOCK_BYTES);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    pk_data_q, pk_data_d;
  logic [CNT_W-1:0] pk_cnt_q, pk_cnt_d;
  logic             pk_close_q, pk_close_d;
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_last_q, out_last_d;
  logic             done_q, done_d;
  logic             in_ready_s;
  logic             out_free_s;
  logic [CNT_W-1:0] pk_cnt_inc_s;

  assign out_free_s   = ~out_valid_q | out_ready;
  assign pk_cnt_inc_s = pk_cnt_q + CNT_W'(1);

  // Next-state logic: packing, block transfer to the output register, DONE handling.
  always_comb begin
    state_d     = state_q;
    pk_data_d   = pk_data_q;
    pk_cnt_d    = pk_cnt_q;
    pk_close_d  = pk_close_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_last_d  = out_last_q;
    done_d      = done_q;
    in_ready_s  = 1'b0;
    // A consumed block leaves the output empty unless something reloads it below.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    case (state_q)
      S_FILL: begin
        in_ready_s = 1'b1;
        if (in_valid) begin
          pk_data_d  = {pk_data_q[DW-9:0], in_data};
          pk_cnt_d   = pk_cnt_inc_s;
          pk_close_d = in_last;
          if (in_last || (pk_cnt_inc_s == FULL_CNT)) begin
            state_d = S_XFER;
          end else begin
            state_d = S_FILL;
          end
        end else begin
          state_d = S_FILL;
        end
      end
      S_XFER: begin
        // Same-cycle consume and reload keeps out_valid high with no bubble.
        if (out_free_s) begin
          out_data_d  = pk_data_q;
          out_count_d = pk_cnt_q;
          out_last_d  = pk_close_q;
          out_valid_d = 1'b1;
          pk_data_d   = '0;
          pk_cnt_d    = '0;
          pk_close_d  = 1'b0;
          if (pk_close_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_FILL;
          end
        end else begin
          state_d = S_XFER;
        end
      end
      S_DONE: begin
        if (start) begin
          state_d = S_FILL;
          done_d  = 1'b0;
        end else begin
`ifdef FETCH_NOOP_EN
          if (out_free_s) begin
            out_data_d  = '0;
            out_count_d = '0;
            out_last_d  = 1'b0;
            out_valid_d = 1'b1;
          end else begin
            out_valid_d = 1'b1;
          end
`else
          state_d = S_DONE;
`endif
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  // State, pack and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_FILL;
      pk_data_q   <= '0;
      pk_cnt_q    <= '0;
      pk_close_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pk_data_q   <= pk_data_d;
      pk_cnt_q    <= pk_cnt_d;
      pk_close_q  <= pk_close_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_last  = out_last_q;
  assign done      = done_q;

endmodule
